// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared packet layout, type encodings and reply builder for
//                Top_bus device endpoints.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  localparam int         PCKG_SZ   = 65;
  localparam logic [2:0] BROADCAST = 3'b111;

  // Field bit positions within a packet
  localparam int DEST_HI = 64;
  localparam int DEST_LO = 62;
  localparam int TYPE_HI = 61;
  localparam int TYPE_LO = 60;
  localparam int SRC_HI  = 59;
  localparam int SRC_LO  = 57;
  localparam int ADDR_HI = 56;
  localparam int ADDR_LO = 53;
  localparam int DATA_HI = 31;
  localparam int DATA_LO = 0;

  typedef enum logic [1:0] {
    PKT_WRITE = 2'b00,
    PKT_READ  = 2'b01,
    PKT_RESP  = 2'b10,
    PKT_PING  = 2'b11
  } pkt_type_e;

  typedef struct packed {
    logic [2:0]  dest;
    pkt_type_e   ptype;
    logic [2:0]  src;
    logic [3:0]  addr;
    logic [20:0] rsvd;
    logic [31:0] data;
  } bus_pkt_t;

  // Reply packets always carry the RESP type; the 57-bit tail is
  // everything below the src field.
  function automatic bus_pkt_t make_resp(input logic [2:0]  dest,
                                         input logic [2:0]  src,
                                         input logic [56:0] tail);
    bus_pkt_t p;
    p = bus_pkt_t'({dest, PKT_RESP, src, tail});
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/responder_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : responder_fifo
//  Description : Synchronous FIFO with occupancy count; a push and a pop on
//                the same edge are both honoured.
//  Revision    : 1.0 - initial release
// ============================================================================
module responder_fifo #(
  parameter  int WIDTH = bus_pkg::PCKG_SZ,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_count == c_depth);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A pop frees a slot on the same edge, so a push into a full FIFO is
  // allowed when it is paired with a pop.
  assign w_rd = pop && !empty;
  assign w_wr = push && (!full || w_rd);

  // Storage array; contents need no reset since occupancy tracks validity
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/device_responder.sv
`default_nettype none
// ============================================================================
//  Module      : device_responder
//  Description : Bus target endpoint. Pops packets for this ID (or broadcast
//                writes), services WRITE/READ/PING against a 16x32 register
//                file and queues RESP packets back onto the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module device_responder #(
  parameter logic [2:0] MY_ID   = 3'd1,
  parameter int         DEPTH   = 4,
  parameter int         PCKG_SZ = 65
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng,
  input  logic [PCKG_SZ-1:0] D_pop,
  output logic               pop,
  output logic               push,
  output logic [PCKG_SZ-1:0] D_push,
  output logic [15:0]        rx_count,
  output logic [15:0]        drop_count
);

  import bus_pkg::*;

  localparam int            CW          = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_depth     = CW'(DEPTH);
  localparam logic [1:0]    c_st_idle   = 2'd0;
  localparam logic [1:0]    c_st_pop    = 2'd1;
  localparam logic [1:0]    c_st_decode = 2'd2;

  // Receive FSM
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               w_start;
  logic               w_pop_nxt;
  logic               w_decode;
  logic               r_pop;
  logic [PCKG_SZ-1:0] r_pkt;

  // Decoded fields of the latched packet
  logic [2:0]         w_dest;
  pkt_type_e          w_type;
  logic [2:0]         w_src;
  logic [3:0]         w_addr;
  logic [31:0]        w_data;
  logic               w_accept;
  logic               w_need_reply;
  logic [56:0]        w_reply_tail;
  bus_pkt_t           w_reply;
  logic [PCKG_SZ-1:0] w_reply_bits;
  logic               w_enq;

  // Register file and statistics
  logic [31:0]        r_regs [16];
  logic [15:0]        r_rx_count;
  logic [15:0]        r_drop_count;

  // Reply queue and transmitter
  logic               w_fifo_push;
  logic               w_fifo_pop;
  logic [PCKG_SZ-1:0] w_fifo_dout;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CW-1:0]      w_fifo_count;
  logic               w_tx_valid;
  logic [PCKG_SZ-1:0] w_tx_data;
  logic               w_tx_fire;
  logic               w_tx_hold;
  logic               r_push;
  logic [PCKG_SZ-1:0] r_d_push;

  // Transmitter stall tie-off; inactive in normal operation
  assign w_tx_hold = 1'b0;

  // ---------------------------------------------------------------------------
  // Receive side
  // ---------------------------------------------------------------------------
  // Only start a transaction when a reply slot is guaranteed; the FSM is
  // serial so nothing else can enqueue before this packet's DECODE.
  assign w_start = (r_state == c_st_idle) && pndng && (w_fifo_count < c_depth);

  // State register, pop strobe and packet capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_pop   <= 1'b0;
      r_pkt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pop   <= w_pop_nxt;
      if (w_start) r_pkt <= D_pop;
    end
  end

  // Next-state logic: fixed IDLE -> POP -> DECODE loop
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (w_start) w_state_nxt = c_st_pop;
      c_st_pop:    w_state_nxt = c_st_decode;
      c_st_decode: w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  // Output decode: pop is registered from the upcoming state
  always_comb begin
    w_pop_nxt = (w_state_nxt == c_st_pop);
    w_decode  = (r_state == c_st_decode);
  end

  assign w_dest = r_pkt[DEST_HI:DEST_LO];
  assign w_type = pkt_type_e'(r_pkt[TYPE_HI:TYPE_LO]);
  assign w_src  = r_pkt[SRC_HI:SRC_LO];
  assign w_addr = r_pkt[ADDR_HI:ADDR_LO];
  assign w_data = r_pkt[DATA_HI:DATA_LO];

  // Broadcast READ/PING are refused so a single request cannot trigger
  // replies from every device at once.
  assign w_accept = ((w_dest == MY_ID)     && (w_type != PKT_RESP)) ||
                    ((w_dest == BROADCAST) && (w_type == PKT_WRITE));

  assign w_need_reply = w_accept && ((w_type == PKT_READ) || (w_type == PKT_PING));

  // READ returns the current register; PING echoes the original tail
  assign w_reply_tail = (w_type == PKT_READ) ? {w_addr, 21'b0, r_regs[w_addr]}
                                             : r_pkt[ADDR_HI:0];
  assign w_reply      = make_resp(w_src, MY_ID, w_reply_tail);
  assign w_reply_bits = w_reply;
  assign w_enq        = w_decode && w_need_reply && !w_fifo_full;

  // Register file writes and saturating accept/drop counters
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      r_rx_count   <= '0;
      r_drop_count <= '0;
    end else if (w_decode) begin
      if (w_accept) begin
        if (w_type == PKT_WRITE) r_regs[w_addr] <= w_data;
        if (r_rx_count != 16'hFFFF) r_rx_count <= r_rx_count + 16'd1;
      end else begin
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit side
  // ---------------------------------------------------------------------------
  // A reply produced while the queue is empty bypasses storage so it can
  // leave on the same edge it is generated.
  assign w_tx_valid  = !w_fifo_empty || w_enq;
  assign w_tx_data   = w_fifo_empty ? w_reply_bits : w_fifo_dout;
  assign w_tx_fire   = w_tx_valid && !r_push && !w_tx_hold;
  assign w_fifo_pop  = w_tx_fire && !w_fifo_empty;
  assign w_fifo_push = w_enq && !(w_fifo_empty && w_tx_fire);

  responder_fifo #(
    .WIDTH (PCKG_SZ),
    .DEPTH (DEPTH)
  ) u_reply_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (w_fifo_push),
    .din   (w_reply_bits),
    .pop   (w_fifo_pop),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  // Push strobe with a mandatory idle cycle after each push; data is zero
  // whenever push is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_push   <= 1'b0;
      r_d_push <= '0;
    end else if (w_tx_fire) begin
      r_push   <= 1'b1;
      r_d_push <= w_tx_data;
    end else begin
      r_push   <= 1'b0;
      r_d_push <= '0;
    end
  end

  assign pop        = r_pop;
  assign push       = r_push;
  assign D_push     = r_d_push;
  assign rx_count   = r_rx_count;
  assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_device_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_device_responder
//  Description : Directed self-checking bench for device_responder with a
//                simple bus model feeding pndng/D_pop and logging pushes.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_device_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  logic [64:0] D_pop;
  logic        pop;
  logic        push;
  logic [64:0] D_push;
  logic [15:0] rx_count;
  logic [15:0] drop_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [64:0] bus_q [$];
  logic [64:0] rsp_q [$];
  int          rsp_cyc [$];
  int          pop_cyc [$];

  device_responder #(
    .MY_ID   (3'd1),
    .DEPTH   (4),
    .PCKG_SZ (65)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pndng      (pndng),
    .D_pop      (D_pop),
    .pop        (pop),
    .push       (push),
    .D_push     (D_push),
    .rx_count   (rx_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Bus model: consumes the head on pop, logs pushes, presents the next head
  always @(negedge clk) begin
    if (!reset) begin
      if (pop) begin
        pop_cyc.push_back(cyc);
        if (bus_q.size() > 0) void'(bus_q.pop_front());
      end
      if (push) begin
        rsp_q.push_back(D_push);
        rsp_cyc.push_back(cyc);
      end
    end
    pndng = (bus_q.size() > 0);
    D_pop = pndng ? bus_q[0] : '0;
  end

  function automatic logic [64:0] mk(input logic [2:0] dest, input logic [1:0] t,
                                     input logic [2:0] src, input logic [3:0] addr,
                                     input logic [31:0] data);
    return {dest, t, src, addr, 21'b0, data};
  endfunction

  task automatic clear_logs();
    rsp_q.delete();
    rsp_cyc.delete();
    pop_cyc.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic send(input logic [64:0] p);
    bus_q.push_back(p);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (pop !== 1'b0) begin failures++; $display("FAIL reset_pop got=%b exp=0", pop); end
    checks++; if (push !== 1'b0) begin failures++; $display("FAIL reset_push got=%b exp=0", push); end
    checks++; if (D_push !== 65'd0) begin failures++; $display("FAIL reset_dpush got=%h exp=0", D_push); end
    checks++; if (rx_count !== 16'd0) begin failures++; $display("FAIL reset_rx got=%0d exp=0", rx_count); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
  endtask

  task automatic test_write_read();
    logic [64:0] got;
    logic [64:0] exp;
    int          lat;
    do_reset();
    send(mk(3'd1, 2'b00, 3'd0, 4'h3, 32'hDEAD_BEEF));
    send(mk(3'd1, 2'b01, 3'd0, 4'h3, 32'h0));
    wait_cycles(20);
    exp = {3'b000, 2'b10, 3'b001, 4'h3, 21'b0, 32'hDEADBEEF};
    got = (rsp_q.size() > 0) ? rsp_q[0] : 'x;
    lat = (rsp_cyc.size() > 0 && pop_cyc.size() > 1) ? rsp_cyc[0] - pop_cyc[1] : -1;
    checks++; if (rsp_q.size() !== 1) begin failures++; $display("FAIL wr_push_count got=%0d exp=1", rsp_q.size()); end
    checks++; if (got !== exp) begin failures++; $display("FAIL wr_read_data got=%h exp=%h", got, exp); end
    checks++; if (pop_cyc.size() !== 2) begin failures++; $display("FAIL wr_pop_count got=%0d exp=2", pop_cyc.size()); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    checks++; if (rx_count !== 16'd2) begin failures++; $display("FAIL wr_rx got=%0d exp=2", rx_count); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL wr_drop got=%0d exp=0", drop_count); end
  endtask

  task automatic test_ping();
    logic [64:0] got;
    logic [64:0] exp;
    do_reset();
    send({3'd1, 2'b11, 3'd2, 57'h1_2345});
    wait_cycles(15);
    exp = {3'd2, 2'b10, 3'd1, 57'h1_2345};
    got = (rsp_q.size() > 0) ? rsp_q[0] : 'x;
    checks++; if (rsp_q.size() !== 1) begin failures++; $display("FAIL ping_push_count got=%0d exp=1", rsp_q.size()); end
    checks++; if (got !== exp) begin failures++; $display("FAIL ping_reply got=%h exp=%h", got, exp); end
    checks++; if (rx_count !== 16'd1) begin failures++; $display("FAIL ping_rx got=%0d exp=1", rx_count); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL ping_drop got=%0d exp=0", drop_count); end
  endtask

  task automatic test_broadcast();
    logic [64:0] got;
    logic [64:0] exp;
    do_reset();
    send(mk(3'd7, 2'b00, 3'd0, 4'h5, 32'hCAFE_0005));
    send(mk(3'd7, 2'b01, 3'd0, 4'h5, 32'h0));
    wait_cycles(20);
    checks++; if (rsp_q.size() !== 0) begin failures++; $display("FAIL bc_no_push got=%0d exp=0", rsp_q.size()); end
    checks++; if (pop_cyc.size() !== 2) begin failures++; $display("FAIL bc_pops got=%0d exp=2", pop_cyc.size()); end
    checks++; if (rx_count !== 16'd1) begin failures++; $display("FAIL bc_rx got=%0d exp=1", rx_count); end
    checks++; if (drop_count !== 16'd1) begin failures++; $display("FAIL bc_drop got=%0d exp=1", drop_count); end
    send(mk(3'd1, 2'b01, 3'd6, 4'h5, 32'h0));
    wait_cycles(15);
    exp = {3'd6, 2'b10, 3'd1, 4'h5, 21'b0, 32'hCAFE0005};
    got = (rsp_q.size() > 0) ? rsp_q[0] : 'x;
    checks++; if (rsp_q.size() !== 1) begin failures++; $display("FAIL bc_readback_count got=%0d exp=1", rsp_q.size()); end
    checks++; if (got !== exp) begin failures++; $display("FAIL bc_readback got=%h exp=%h", got, exp); end
  endtask

  task automatic test_drop();
    logic [64:0] got;
    logic [64:0] exp;
    do_reset();
    send(mk(3'd4, 2'b00, 3'd0, 4'h2, 32'h1111_1111));
    send(mk(3'd1, 2'b10, 3'd3, 4'h2, 32'h2222_2222));
    wait_cycles(20);
    checks++; if (pop_cyc.size() !== 2) begin failures++; $display("FAIL drop_pops got=%0d exp=2", pop_cyc.size()); end
    checks++; if (rsp_q.size() !== 0) begin failures++; $display("FAIL drop_no_push got=%0d exp=0", rsp_q.size()); end
    checks++; if (drop_count !== 16'd2) begin failures++; $display("FAIL drop_count got=%0d exp=2", drop_count); end
    checks++; if (rx_count !== 16'd0) begin failures++; $display("FAIL drop_rx got=%0d exp=0", rx_count); end
    send(mk(3'd1, 2'b01, 3'd0, 4'h2, 32'h0));
    wait_cycles(15);
    exp = {3'd0, 2'b10, 3'd1, 4'h2, 21'b0, 32'h0};
    got = (rsp_q.size() > 0) ? rsp_q[0] : 'x;
    checks++; if (got !== exp) begin failures++; $display("FAIL drop_reg_untouched got=%h exp=%h", got, exp); end
  endtask

  task automatic test_backpressure();
    logic [64:0] got;
    logic [64:0] exp;
    int          min_gap;
    do_reset();
    for (int i = 0; i < 6; i++) send(mk(3'd1, 2'b00, 3'd0, 4'(i), 32'h100 + 32'(i)));
    wait_cycles(40);
    clear_logs();
    force dut.w_tx_hold = 1'b1;
    for (int i = 0; i < 6; i++) send(mk(3'd1, 2'b01, 3'd3, 4'(i), 32'h0));
    wait_cycles(40);
    checks++; if (pop_cyc.size() !== 4) begin failures++; $display("FAIL bp_pops_stalled got=%0d exp=4", pop_cyc.size()); end
    checks++; if (bus_q.size() !== 2) begin failures++; $display("FAIL bp_bus_left got=%0d exp=2", bus_q.size()); end
    checks++; if (rsp_q.size() !== 0) begin failures++; $display("FAIL bp_no_push got=%0d exp=0", rsp_q.size()); end
    release dut.w_tx_hold;
    wait_cycles(60);
    checks++; if (rsp_q.size() !== 6) begin failures++; $display("FAIL bp_reply_count got=%0d exp=6", rsp_q.size()); end
    for (int i = 0; i < 6; i++) begin
      exp = {3'd3, 2'b10, 3'd1, 4'(i), 21'b0, 32'h100 + 32'(i)};
      got = (rsp_q.size() > i) ? rsp_q[i] : 'x;
      checks++; if (got !== exp) begin failures++; $display("FAIL bp_reply_%0d got=%h exp=%h", i, got, exp); end
    end
    min_gap = 1000;
    for (int i = 1; i < rsp_cyc.size(); i++)
      if (rsp_cyc[i] - rsp_cyc[i-1] < min_gap) min_gap = rsp_cyc[i] - rsp_cyc[i-1];
    checks++; if (min_gap < 2) begin failures++; $display("FAIL bp_push_gap got=%0d exp>=2", min_gap); end
    checks++; if (pop_cyc.size() !== 6) begin failures++; $display("FAIL bp_pops_total got=%0d exp=6", pop_cyc.size()); end
    checks++; if (rx_count !== 16'd12) begin failures++; $display("FAIL bp_rx got=%0d exp=12", rx_count); end
  endtask

  task automatic test_reset_mid();
    logic [64:0] got;
    logic [64:0] exp;
    logic        seen;
    do_reset();
    send(mk(3'd1, 2'b00, 3'd0, 4'h7, 32'h0000_0077));
    wait_cycles(12);
    clear_logs();
    send(mk(3'd1, 2'b01, 3'd0, 4'h7, 32'h0));
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (pop === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL mid_pop_timeout got=%b exp=1", seen); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_cycles(10);
    checks++; if (rsp_q.size() !== 0) begin failures++; $display("FAIL mid_no_push got=%0d exp=0", rsp_q.size()); end
    checks++; if (rx_count !== 16'd0) begin failures++; $display("FAIL mid_rx got=%0d exp=0", rx_count); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL mid_drop got=%0d exp=0", drop_count); end
    send(mk(3'd1, 2'b01, 3'd0, 4'h7, 32'h0));
    wait_cycles(15);
    exp = {3'd0, 2'b10, 3'd1, 4'h7, 21'b0, 32'h0};
    got = (rsp_q.size() > 0) ? rsp_q[0] : 'x;
    checks++; if (got !== exp) begin failures++; $display("FAIL mid_reg_cleared got=%h exp=%h", got, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pndng = 1'b0;
    D_pop = '0;
    test_reset();
    test_write_read();
    test_ping();
    test_broadcast();
    test_drop();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
